// File: rtl/rca_wb_drain.sv
// Receives RCA writeback bundles, buffers them in a small FIFO and drains the head bundle
// into the register file through RF_WR_PORTS lanes, pulsing a commit when a bundle is done.
module rca_wb_drain #(
    parameter int unsigned NUM_WRITE_PORTS = 5,
    parameter int unsigned RF_WR_PORTS     = 2,
    parameter int unsigned XLEN            = 32,
    parameter int unsigned ID_W            = 3,
    parameter int unsigned DEPTH           = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [ID_W-1:0]                   in_id,
    input  logic [NUM_WRITE_PORTS*XLEN-1:0]   in_rd,
    input  logic [NUM_WRITE_PORTS*5-1:0]      in_dest_addr,
    input  logic [NUM_WRITE_PORTS-1:0]        in_port_en,
    output logic [RF_WR_PORTS-1:0]            rf_we,
    output logic [RF_WR_PORTS*5-1:0]          rf_addr,
    output logic [RF_WR_PORTS*XLEN-1:0]       rf_data,
    output logic                              commit_valid,
    output logic [ID_W-1:0]                   commit_id,
    output logic                              busy
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [ID_W-1:0]                 r_id   [DEPTH];
    logic [NUM_WRITE_PORTS*XLEN-1:0] r_rd   [DEPTH];
    logic [NUM_WRITE_PORTS*5-1:0]    r_addr [DEPTH];
    logic [NUM_WRITE_PORTS-1:0]      r_mask [DEPTH];
    logic [PW-1:0]                   r_rptr;
    logic [PW-1:0]                   r_wptr;
    logic [CW-1:0]                   r_count;
    logic                            r_commit_valid;
    logic [ID_W-1:0]                 r_commit_id;

    logic                       w_push;
    logic                       w_pop;
    logic [NUM_WRITE_PORTS-1:0] w_in_mask;
    logic [NUM_WRITE_PORTS-1:0] w_head_mask;
    logic [NUM_WRITE_PORTS-1:0] w_issue;
    logic [NUM_WRITE_PORTS-1:0] w_mask_next;
    logic [NUM_WRITE_PORTS-1:0] w_rem;
    logic                       w_found;
    logic                       w_lane_v    [RF_WR_PORTS];
    logic [4:0]                 w_lane_addr [RF_WR_PORTS];
    logic [XLEN-1:0]            w_lane_data [RF_WR_PORTS];

    assign busy         = (r_count != '0);
    assign in_ready     = (r_count != FULL_CNT);
    assign w_push       = in_valid && in_ready;
    assign w_head_mask  = busy ? r_mask[r_rptr] : '0;
    assign w_mask_next  = w_head_mask & ~w_issue;
    assign w_pop        = busy && (w_mask_next == '0);
    assign commit_valid = r_commit_valid;
    assign commit_id    = r_commit_id;

    always_comb begin
        for (int i = 0; i < NUM_WRITE_PORTS; i++) begin
            w_in_mask[i] = in_port_en[i] && (in_dest_addr[i*5 +: 5] != 5'd0);
        end
    end

    // Lane k takes the k-th lowest pending result of the head bundle.
    always_comb begin
        w_issue = '0;
        w_rem   = w_head_mask;
        w_found = 1'b0;
        for (int k = 0; k < RF_WR_PORTS; k++) begin
            w_lane_v[k]    = 1'b0;
            w_lane_addr[k] = '0;
            w_lane_data[k] = '0;
            w_found        = 1'b0;
            for (int i = 0; i < NUM_WRITE_PORTS; i++) begin
                if (!w_found && w_rem[i]) begin
                    w_found        = 1'b1;
                    w_rem[i]       = 1'b0;
                    w_issue[i]     = 1'b1;
                    w_lane_v[k]    = 1'b1;
                    w_lane_addr[k] = r_addr[r_rptr][i*5 +: 5];
                    w_lane_data[k] = r_rd[r_rptr][i*XLEN +: XLEN];
                end
            end
        end
    end

    // Higher lanes hold higher result indices, so a later lane to the same register wins.
    always_comb begin
        rf_we   = '0;
        rf_addr = '0;
        rf_data = '0;
        for (int k = 0; k < RF_WR_PORTS; k++) begin
            rf_we[k]              = w_lane_v[k];
            rf_addr[k*5 +: 5]     = w_lane_addr[k];
            rf_data[k*XLEN +: XLEN] = w_lane_data[k];
            for (int j = k + 1; j < RF_WR_PORTS; j++) begin
                if (w_lane_v[k] && w_lane_v[j] && (w_lane_addr[k] == w_lane_addr[j])) begin
                    rf_we[k] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rptr         <= '0;
            r_wptr         <= '0;
            r_count        <= '0;
            r_commit_valid <= 1'b0;
            r_commit_id    <= '0;
            for (int d = 0; d < DEPTH; d++) begin
                r_mask[d] <= '0;
            end
        end else begin
            r_commit_valid <= w_pop;
            if (w_pop) begin
                r_commit_id <= r_id[r_rptr];
                r_rptr      <= r_rptr + 1'b1;
            end
            if (busy) begin
                r_mask[r_rptr] <= w_mask_next;
            end
            if (w_push) begin
                r_mask[r_wptr] <= w_in_mask;
                r_wptr         <= r_wptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_id[r_wptr]   <= in_id;
            r_rd[r_wptr]   <= in_rd;
            r_addr[r_wptr] <= in_dest_addr;
        end
    end

endmodule

// File: tb/tb_rca_wb_drain.sv
// Self-checking bench for rca_wb_drain: directed vector table, reset/back-to-back sequences
// and randomized traffic compared against a queue-based reference model.
module tb_rca_wb_drain;

    localparam int NWP = 5;
    localparam int RFP = 2;
    localparam int XL  = 32;
    localparam int IDW = 3;
    localparam int DEP = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [IDW-1:0]   in_id;
    logic [NWP*XL-1:0] in_rd;
    logic [NWP*5-1:0] in_dest_addr;
    logic [NWP-1:0]   in_port_en;
    logic [RFP-1:0]   rf_we;
    logic [RFP*5-1:0] rf_addr;
    logic [RFP*XL-1:0] rf_data;
    logic             commit_valid;
    logic [IDW-1:0]   commit_id;
    logic             busy;

    rca_wb_drain #(
        .NUM_WRITE_PORTS(NWP), .RF_WR_PORTS(RFP), .XLEN(XL), .ID_W(IDW), .DEPTH(DEP)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id),
        .in_rd(in_rd), .in_dest_addr(in_dest_addr), .in_port_en(in_port_en),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
        .commit_valid(commit_valid), .commit_id(commit_id), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]   id;
        logic [159:0] rd;
        logic [24:0]  addr;
        logic [4:0]   mask;
    } bun_t;

    typedef struct {
        logic [2:0]   id;
        logic [159:0] rd;
        logic [24:0]  addr;
        logic [4:0]   en;
        logic [1:0]   f_we;
        logic [9:0]   f_addr;
        logic [63:0]  f_data;
        int           lat;
    } vec_t;

    bun_t       q[$];
    logic       m_cv;
    logic [2:0] m_cid;
    logic [2:0] got_q[$];
    int         n_chk = 0;
    int         n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [159:0] p_rd(input int a, input int b, input int c, input int d,
                                          input int e);
        return {32'(e), 32'(d), 32'(c), 32'(b), 32'(a)};
    endfunction

    function automatic logic [24:0] p_ad(input int a, input int b, input int c, input int d,
                                         input int e);
        return {5'(e), 5'(d), 5'(c), 5'(b), 5'(a)};
    endfunction

    // Expected lane outputs: the two lowest pending results of the oldest bundle.
    function automatic void model_out(output logic [1:0] we, output logic [9:0] a,
                                      output logic [63:0] d);
        int k;
        we = '0;
        a  = '0;
        d  = '0;
        k  = 0;
        if (q.size() == 0) return;
        for (int i = 0; i < NWP; i++) begin
            if (q[0].mask[i] && k < 2) begin
                if (k == 0) begin
                    we[0] = 1'b1; a[4:0] = q[0].addr[i*5 +: 5]; d[31:0] = q[0].rd[i*32 +: 32];
                end else begin
                    we[1] = 1'b1; a[9:5] = q[0].addr[i*5 +: 5]; d[63:32] = q[0].rd[i*32 +: 32];
                end
                k++;
            end
        end
        if (we == 2'b11 && a[4:0] == a[9:5]) we[0] = 1'b0;
    endfunction

    task automatic model_step();
        int   sz;
        int   cnt;
        bun_t h;
        bun_t nb;
        sz   = q.size();
        m_cv = 1'b0;
        if (sz > 0) begin
            h   = q[0];
            cnt = 0;
            for (int i = 0; i < NWP; i++) begin
                if (h.mask[i] && cnt < 2) begin
                    h.mask[i] = 1'b0;
                    cnt++;
                end
            end
            q[0] = h;
            if (h.mask == '0) begin
                m_cv  = 1'b1;
                m_cid = h.id;
                void'(q.pop_front());
            end
        end
        if (in_valid && sz < DEP) begin
            nb.id   = in_id;
            nb.rd   = in_rd;
            nb.addr = in_dest_addr;
            for (int i = 0; i < NWP; i++) begin
                nb.mask[i] = in_port_en[i] && (in_dest_addr[i*5 +: 5] != 5'd0);
            end
            q.push_back(nb);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_cv  = 1'b0;
        m_cid = '0;
    endtask

    task automatic cycle();
        logic [1:0]  ew;
        logic [9:0]  ea;
        logic [63:0] ed;
        model_out(ew, ea, ed);
        chk("in_ready", 64'(in_ready), 64'(q.size() < DEP));
        chk("busy", 64'(busy), 64'(q.size() != 0));
        chk("rf_we", 64'(rf_we), 64'(ew));
        chk("rf_addr", 64'(rf_addr), 64'(ea));
        chk("rf_data", 64'(rf_data), ed);
        chk("commit_valid", 64'(commit_valid), 64'(m_cv));
        chk("commit_id", 64'(commit_id), 64'(m_cid));
        if (commit_valid) got_q.push_back(commit_id);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        in_valid     = 1'b1;
        in_id        = v.id;
        in_rd        = v.rd;
        in_dest_addr = v.addr;
        in_port_en   = v.en;
    endtask

    vec_t tbl[4];
    int   n;
    logic saw_full;
    int   guard;

    initial begin
        tbl[0] = '{3'd3, p_rd(10, 20, 30, 40, 50), p_ad(1, 2, 3, 4, 5), 5'b11111,
                   2'b11, {5'd2, 5'd1}, {32'd20, 32'd10}, 4};
        tbl[1] = '{3'd6, p_rd(100, 101, 102, 103, 104), p_ad(0, 7, 9, 7, 12), 5'b10101,
                   2'b11, {5'd12, 5'd9}, {32'd104, 32'd102}, 2};
        tbl[2] = '{3'd2, p_rd(32'hA, 32'hB, 0, 0, 0), p_ad(6, 6, 0, 0, 0), 5'b00011,
                   2'b10, {5'd6, 5'd6}, {32'hB, 32'hA}, 2};
        tbl[3] = '{3'd5, p_rd(1, 2, 3, 4, 5), p_ad(1, 2, 3, 4, 5), 5'b00000,
                   2'b00, 10'd0, 64'd0, 2};

        rst          = 1'b1;
        in_valid     = 1'b0;
        in_id        = '0;
        in_rd        = '0;
        in_dest_addr = '0;
        in_port_en   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_rf_addr", 64'(rf_addr), 64'd0);
        chk("rst_rf_data", 64'(rf_data), 64'd0);
        chk("rst_commit_valid", 64'(commit_valid), 64'd0);
        chk("rst_commit_id", 64'(commit_id), 64'd0);
        rst = 1'b0;

        // Reset in the middle of draining a full bundle.
        drive(tbl[0]);
        cycle();
        in_valid = 1'b0;
        chk("pre_rst_we", 64'(rf_we), 64'd3);
        rst = 1'b1;
        #1;
        chk("mid_rst_we", 64'(rf_we), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) cycle();

        // Directed vector table.
        for (int t = 0; t < 4; t++) begin
            drive(tbl[t]);
            cycle();
            in_valid = 1'b0;
            chk($sformatf("tbl%0d_we", t), 64'(rf_we), 64'(tbl[t].f_we));
            chk($sformatf("tbl%0d_addr", t), 64'(rf_addr), 64'(tbl[t].f_addr));
            chk($sformatf("tbl%0d_data", t), 64'(rf_data), tbl[t].f_data);
            n = 1;
            while (!commit_valid && n < 12) begin
                cycle();
                n++;
            end
            chk($sformatf("tbl%0d_lat", t), 64'(n), 64'(tbl[t].lat));
            chk($sformatf("tbl%0d_cid", t), 64'(commit_id), 64'(tbl[t].id));
            cycle();
            chk($sformatf("tbl%0d_pulse", t), 64'(commit_valid), 64'd0);
        end

        // Back-to-back full bundles, more than the FIFO holds.
        got_q.delete();
        saw_full = 1'b0;
        for (int b = 0; b < 3; b++) begin
            in_valid   = 1'b1;
            in_id      = (b == 0) ? 3'd1 : (b == 1) ? 3'd2 : 3'd4;
            in_rd      = {$urandom, $urandom, $urandom, $urandom, $urandom};
            in_port_en = 5'b11111;
            for (int i = 0; i < NWP; i++) in_dest_addr[i*5 +: 5] = 5'($urandom_range(1, 31));
            guard = 0;
            while (q.size() >= DEP && guard < 20) begin
                if (!in_ready) saw_full = 1'b1;
                cycle();
                guard++;
            end
            chk("b2b_accept_bound", 64'(guard < 20), 64'd1);
            cycle();
        end
        in_valid = 1'b0;
        repeat (14) cycle();
        chk("b2b_saw_full", 64'(saw_full), 64'd1);
        chk("b2b_ncommits", 64'(got_q.size()), 64'd3);
        if (got_q.size() == 3) begin
            chk("b2b_order0", 64'(got_q[0]), 64'd1);
            chk("b2b_order1", 64'(got_q[1]), 64'd2);
            chk("b2b_order2", 64'(got_q[2]), 64'd4);
        end

        // Randomized traffic with small register range to hit x0 and same-address cases.
        for (int c = 0; c < 400; c++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_id      = 3'($urandom);
            in_rd      = {$urandom, $urandom, $urandom, $urandom, $urandom};
            in_port_en = 5'($urandom);
            for (int i = 0; i < NWP; i++) in_dest_addr[i*5 +: 5] = 5'($urandom_range(0, 7));
            cycle();
        end
        in_valid = 1'b0;
        repeat (12) cycle();
        chk("final_idle", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/rca_wb_drain.md
Name: rca_wb_drain

Overview:
- Receiving end of the RCA writeback interface. Accepts result bundles of NUM_WRITE_PORTS values from the RCA unit, together with their destination register addresses.
- Buffers bundles in a small FIFO and drains them into the register file through RF_WR_PORTS write lanes per cycle.
- Emits one commit pulse, carrying the instruction id, when every result of a bundle has been written.
- Sits between rca_unit writeback and the register file / writeback commit logic.

Parameters:
- NUM_WRITE_PORTS, 5, results per RCA bundle.
- RF_WR_PORTS, 2, register-file write lanes per cycle (1..NUM_WRITE_PORTS).
- XLEN, 32, data width.
- ID_W, 3, instruction id width.
- DEPTH, 2, bundle FIFO depth (power of 2, >=2).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  bundle offered (RCA wb done).
- in_ready  out  1  bundle can be accepted.
- in_id  in  ID_W  instruction id of the bundle.
- in_rd  in  NUM_WRITE_PORTS x XLEN  result values.
- in_dest_addr  in  NUM_WRITE_PORTS x 5  destination register per result.
- in_port_en  in  NUM_WRITE_PORTS  result lane used.
- rf_we  out  RF_WR_PORTS  write enable per lane.
- rf_addr  out  RF_WR_PORTS x 5  write address per lane.
- rf_data  out  RF_WR_PORTS x XLEN  write data per lane.
- commit_valid  out  1  one-cycle bundle-complete pulse.
- commit_id  out  ID_W  id of the completed bundle.
- busy  out  1  FIFO non-empty.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset: clears the FIFO (count=0, pointers=0) and all pending masks.
  - Reset values: in_ready=1, rf_we=0, rf_addr=0, rf_data=0, commit_valid=0, commit_id=0, busy=0.
  - Reset mid-drain discards all buffered bundles. No further writes or commits occur for them.
- Accept:
  - in_ready = (count != DEPTH).
  - Push on the clk edge where in_valid && in_ready.
  - The stored pending mask is, per lane i, in_port_en[i] && (in_dest_addr[i] != 0). Writes to x0 are dropped.
  - No push when full, even if a pop happens on the same edge.
- Drain (head bundle only):
  - rf_we/rf_addr/rf_data are combinational from the head entry.
  - Lane k carries the k-th lowest-indexed pending result.
  - Lanes with no pending result have rf_we=0, rf_addr=0, rf_data=0.
  - If two issued lanes in the same cycle share an address, only the higher result index keeps rf_we=1. This preserves in-order last-writer-wins.
  - On each edge, issued results are cleared from the head mask.
- Latency: a bundle accepted at edge E is first written in the cycle following E, when it is at the head of an empty FIFO. A full bundle (5 results, RF_WR_PORTS=2) drains over 3 cycles.
- Completion:
  - On the edge where the head's remaining mask becomes zero (or is already zero), the head is popped.
  - commit_valid=1 and commit_id=head id are registered, visible for exactly the cycle after that edge.
  - A bundle with an all-zero mask produces no writes. It pops on the first edge it is at the head, so it still commits.
- Simultaneous push and pop (not full) on one edge: count is unchanged, and the next bundle's writes start the following cycle. There is no bubble between consecutive bundles.
- Ordering: commits leave in acceptance order. Pointers wrap modulo DEPTH.
- busy = (count != 0).

Test Plan:
- After reset, in_ready=1, busy=0, all outputs 0. Assert rst mid-drain of a 5-result bundle -> rf_we=0 in the next cycle, no commit_valid, in_ready=1.
- Push id=3, rd={10,20,30,40,50}, addr={1,2,3,4,5}, port_en=5'b11111 -> three drain cycles:
  - (1,10),(2,20)
  - (3,30),(4,40)
  - (5,50) with lane1 we=0
  - then commit_valid=1, commit_id=3 for one cycle.
- port_en=5'b10101, addr={0,7,9,7,12} (lane0 targets x0) -> lane0 dropped:
  - cycle1: (9,rd2),(12,rd4)
  - commit after one drain cycle.
- Same cycle, equal address: addr={6,6,0,0,0}, port_en=5'b00011, rd={0xA,0xB} -> only lane1 writes (6,0xB); rf_we[0]=0; commit follows.
- Back-to-back pushes id=1, 2, 4 (all full bundles) with DEPTH=2 -> in_ready=0 once 2 bundles are held. Commits arrive 1,2,4 in order, with no idle cycle between drains.
- port_en=0, id=5 -> no rf_we. commit_valid with commit_id=5 in the second cycle after the accept edge.
